// File: rtl/gate_unit_arbiter_pkg.sv
// Shared definitions for the gate-unit arbiter slice: opcode values,
// FSM state encoding and a reserved-opcode helper.
// Optional feature macro: GLU_OP_ERR_EN (opcodes 6/7 become reserved).
package gate_unit_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [2:0] OP_BUF  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Opcodes that are illegal when the reserved-opcode feature is built in.
  function automatic logic op_reserved(input logic [2:0] op);
    return (op == OP_NOT) || (op == OP_BUF);
  endfunction

endpackage

// File: rtl/gate_unit_arbiter_if.sv
// Request/response bundle between NREQ clients and the gate-unit arbiter.
// Optional feature macro: GLU_OP_ERR_EN (adds rsp_err).
interface gate_unit_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*3-1:0]     req_op;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
`ifdef GLU_OP_ERR_EN
  logic                  rsp_err;
`endif

`ifdef GLU_OP_ERR_EN
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
`else
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
`endif

endinterface

// File: rtl/gate_unit_arbiter_mux_logic_unit.sv
// Purely combinational WIDTH-wide logic unit. Every gate is a 2:1 mux
// with operand a as select and b / ~b / constants as data; an 8:1 mux
// on the opcode then picks the gate output.
// Optional feature macro: GLU_OP_ERR_EN (opcodes 6/7 yield zero).
module mux_logic_unit
  import gate_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  function automatic logic mux2(input logic sel, input logic d1, input logic d0);
    return sel ? d1 : d0;
  endfunction

  logic [WIDTH-1:0] g_and, g_or, g_nand, g_nor, g_xor, g_xnor;
`ifndef GLU_OP_ERR_EN
  logic [WIDTH-1:0] g_not, g_buf;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign g_and[i]  = mux2(a[i], b[i],  1'b0);
    assign g_or[i]   = mux2(a[i], 1'b1,  b[i]);
    assign g_nand[i] = mux2(a[i], ~b[i], 1'b1);
    assign g_nor[i]  = mux2(a[i], 1'b0,  ~b[i]);
    assign g_xor[i]  = mux2(a[i], ~b[i], b[i]);
    assign g_xnor[i] = mux2(a[i], b[i],  ~b[i]);
`ifndef GLU_OP_ERR_EN
    assign g_not[i]  = mux2(a[i], 1'b0,  1'b1);
    assign g_buf[i]  = mux2(a[i], 1'b1,  1'b0);
`endif
  end

  // Opcode selection across the gate outputs.
  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = g_and;
      OP_OR:   y = g_or;
      OP_NAND: y = g_nand;
      OP_NOR:  y = g_nor;
      OP_XOR:  y = g_xor;
      OP_XNOR: y = g_xnor;
`ifdef GLU_OP_ERR_EN
      default: y = '0;
`else
      OP_NOT:  y = g_not;
      OP_BUF:  y = g_buf;
      default: y = '0;
`endif
    endcase
  end

endmodule

// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter sharing one mux_logic_unit among NREQ requesters.
// IDLE grants (combinational one-hot ready), EXEC registers the result,
// RESP holds it until rsp_ready. One operation in flight at a time.
// Optional feature macro: GLU_OP_ERR_EN (opcodes 6/7 reserved, rsp_err).
module gate_unit_arbiter
  import gate_unit_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  gate_unit_arbiter_if.slave bus
);

  localparam int unsigned IDW = $clog2(NREQ);

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   winner;
  logic             found;
  logic             accept;
  logic [NREQ-1:0]  ready_c;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] rsp_data_q;
  logic [IDW-1:0]   rsp_id_q;
`ifdef GLU_OP_ERR_EN
  logic             rsp_err_q;
`endif

  // Round-robin pick: first valid requester after ptr, wrapping at NREQ-1.
  always_comb begin : pick
    int unsigned    cand;
    logic [IDW-1:0] cand_id;
    found   = 1'b0;
    winner  = '0;
    cand    = 0;
    cand_id = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_id = cand[IDW-1:0];
      if (!found && bus.req_valid[cand_id]) begin
        found  = 1'b1;
        winner = cand_id;
      end
    end
  end

  // Next-state and grant decode; ready is also masked while reset is held.
  always_comb begin
    state_nxt = state;
    ready_c   = '0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (found && rst_n) begin
          ready_c[winner] = 1'b1;
          accept          = 1'b1;
          state_nxt       = ST_EXEC;
        end
      end
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Operand latch on handshake; ptr doubles as the id of the op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr  <= IDW'(NREQ - 1);
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept) begin
      ptr  <= winner;
      op_q <= bus.req_op[32'(winner)*3 +: 3];
      a_q  <= bus.req_a[32'(winner)*WIDTH +: WIDTH];
      b_q  <= bus.req_b[32'(winner)*WIDTH +: WIDTH];
    end
  end

  mux_logic_unit #(.WIDTH(WIDTH)) u_mlu (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (result)
  );

  // Response registers, loaded in EXEC and held stable through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
`ifdef GLU_OP_ERR_EN
      rsp_err_q  <= 1'b0;
`endif
    end else if (state == ST_EXEC) begin
      rsp_data_q <= result;
      rsp_id_q   <= ptr;
`ifdef GLU_OP_ERR_EN
      rsp_err_q  <= op_reserved(op_q);
`endif
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
`ifdef GLU_OP_ERR_EN
  assign bus.rsp_err   = rsp_err_q;
`endif

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Directed bench for gate_unit_arbiter (NREQ=4, WIDTH=8): reset, single
// requests, every opcode, fairness, wrap/skip, backpressure, mid-op reset.
// Honours GLU_OP_ERR_EN for the opcode 6/7 expectations.
module tb_gate_unit_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   fails  = 0;
  int   total  = 0;

  gate_unit_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();

  gate_unit_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
      $error("check %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.req_op[3*i +: 3] = op;
    bus.req_a[8*i +: 8]  = a;
    bus.req_b[8*i +: 8]  = b;
  endtask

  // Streaming operands: every requester does XOR with 0F.
  task automatic load_tbl();
    set_req(0, 3'd4, 8'h01, 8'h0F);
    set_req(1, 3'd4, 8'h11, 8'h0F);
    set_req(2, 3'd4, 8'h21, 8'h0F);
    set_req(3, 3'd4, 8'h31, 8'h0F);
  endtask

  function automatic logic [7:0] tbl_exp(input int id);
    case (id)
      0:       return 8'h0E;
      1:       return 8'h1E;
      2:       return 8'h2E;
      default: return 8'h3E;
    endcase
  endfunction

  // One full op for a lone requester; starts and ends in IDLE, rsp_ready low.
  task automatic run_one(input int i, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] exp, input string tag);
    set_req(i, op, a, b);
    bus.req_valid    = '0;
    bus.req_valid[i] = 1'b1;
    @(negedge clk);
    chk({tag, "_ready"}, bus.req_ready, 32'd1 << i);
    chk({tag, "_nvld0"}, bus.rsp_valid, 0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    chk({tag, "_nvld1"}, bus.rsp_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_vld"},  bus.rsp_valid, 1);
    chk({tag, "_id"},   bus.rsp_id, i);
    chk({tag, "_data"}, bus.rsp_data, exp);
`ifdef GLU_OP_ERR_EN
    chk({tag, "_err"},  bus.rsp_err, (op >= 3'd6) ? 1 : 0);
`endif
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  // One grant/exec/resp round while valids are held; rsp_ready held high.
  task automatic grant_cycle(input int id, input string tag);
    @(negedge clk);
    chk({tag, "_ready"}, bus.req_ready, 32'd1 << id);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_exec_rdy"}, bus.req_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_vld"},  bus.rsp_valid, 1);
    chk({tag, "_id"},   bus.rsp_id, id);
    chk({tag, "_data"}, bus.rsp_data, tbl_exp(id));
    @(posedge clk); #1;
  endtask

`ifdef GLU_OP_ERR_EN
  localparam logic [7:0] EXP_NOT = 8'h00;
  localparam logic [7:0] EXP_BUF = 8'h00;
`else
  localparam logic [7:0] EXP_NOT = 8'h55;
  localparam logic [7:0] EXP_BUF = 8'hAA;
`endif

  initial begin
    // Reset with every requester asking: nothing may be granted.
    rst_n         = 1'b0;
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    load_tbl();
    #2;
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_vld",   bus.rsp_valid, 0);
    chk("rst_data",  bus.rsp_data, 0);
    chk("rst_id",    bus.rsp_id, 0);
`ifdef GLU_OP_ERR_EN
    chk("rst_err",   bus.rsp_err, 0);
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fairness: all valid, strict rotation starting at requester 0.
    grant_cycle(0, "fair0");
    grant_cycle(1, "fair1");
    grant_cycle(2, "fair2");
    grant_cycle(3, "fair3");
    grant_cycle(0, "fair4");
    grant_cycle(1, "fair5");
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;

    // Single requester 2.
    run_one(2, 3'd4, 8'hF0, 8'h3C, 8'hCC, "single_xor");
    run_one(2, 3'd5, 8'hF0, 8'h3C, 8'h33, "single_xnor");

    // Every opcode from requester 0.
    run_one(0, 3'd0, 8'hAA, 8'hCC, 8'h88, "op_and");
    run_one(0, 3'd1, 8'hAA, 8'hCC, 8'hEE, "op_or");
    run_one(0, 3'd2, 8'hAA, 8'hCC, 8'h77, "op_nand");
    run_one(0, 3'd3, 8'hAA, 8'hCC, 8'h11, "op_nor");
    run_one(0, 3'd4, 8'hAA, 8'hCC, 8'h66, "op_xor");
    run_one(0, 3'd5, 8'hAA, 8'hCC, 8'h99, "op_xnor");
    run_one(0, 3'd6, 8'hAA, 8'hCC, EXP_NOT, "op_not");
    run_one(0, 3'd7, 8'hAA, 8'hCC, EXP_BUF, "op_buf");

    // Wrap/skip: ptr left at 3, only requesters 1 and 3 valid.
    run_one(3, 3'd1, 8'h01, 8'h02, 8'h03, "wrap_pre");
    load_tbl();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1010;
    grant_cycle(1, "wrap0");
    grant_cycle(3, "wrap1");
    grant_cycle(1, "wrap2");
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;

    // Backpressure: requester 1 held in RESP while requester 2 waits.
    set_req(1, 3'd0, 8'hFF, 8'h5A);
    set_req(2, 3'd1, 8'h0F, 8'hF0);
    bus.req_valid = 4'b0010;
    @(negedge clk);
    chk("bp_ready", bus.req_ready, 4'b0010);
    @(posedge clk); #1;
    bus.req_valid = 4'b0100;
    @(negedge clk);
    chk("bp_exec_rdy", bus.req_ready, 0);
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold_vld",  bus.rsp_valid, 1);
      chk("bp_hold_data", bus.rsp_data, 8'h5A);
      chk("bp_hold_id",   bus.rsp_id, 1);
      chk("bp_hold_rdy",  bus.req_ready, 0);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_last_vld", bus.rsp_valid, 1);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_next_ready", bus.req_ready, 4'b0100);
    chk("bp_next_vld",   bus.rsp_valid, 0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_next_id",   bus.rsp_id, 2);
    chk("bp_next_data", bus.rsp_data, 8'hFF);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;

    // Reset while an op for requester 2 sits in EXEC.
    load_tbl();
    bus.req_valid = 4'b0100;
    @(negedge clk);
    chk("mid_ready", bus.req_ready, 4'b0100);
    @(posedge clk); #1;
    bus.req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld",  bus.rsp_valid, 0);
    chk("mid_rst_data", bus.rsp_data, 0);
    chk("mid_rst_id",   bus.rsp_id, 0);
    bus.req_valid = 4'b1001;
    #1;
    chk("mid_rst_ready", bus.req_ready, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_post_ready", bus.req_ready, 4'b0001);
    chk("mid_post_vld0",  bus.rsp_valid, 0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    chk("mid_post_vld1", bus.rsp_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_post_vld",  bus.rsp_valid, 1);
    chk("mid_post_id",   bus.rsp_id, 0);
    chk("mid_post_data", bus.rsp_data, 8'h0E);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("mid_idle_vld", bus.rsp_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
